mem_port_arbiter: RTL and testbench

- Shares one single-ported, fixed-latency unified memory between the instruction fetch stage and the data memory stage of the 5-stage pipeline.
- Sequences each access over LATENCY cycles and returns read data to the requester.
- Generates the fetch-side and memory-side stall signals consumed by hazard/PC-write logic.
- Data port has fixed priority over fetch: the older instruction is always served first.

---
 rtl/mem_port_arbiter.sv | 116 +++++++++++
 tb/tb_mem_port_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported fixed-latency memory between instruction fetch and data access.
// Data has fixed priority over fetch; each access runs LATENCY cycles followed by a one-cycle done pulse.
module mem_port_arbiter #(
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        if_done,
  output logic [15:0] if_rdata,
  output logic        d_done,
  output logic [15:0] d_rdata,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        m_en,
  output logic        m_wr,
  output logic [15:0] m_addr,
  output logic [15:0] m_wdata,
  input  logic [15:0] m_rdata,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_F, RESP} state_t;

  localparam logic [3:0] LAST_CNT = 4'(LATENCY - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       d_req;
  logic       granted_dropped;

  assign d_req = d_rd | d_wr;

  assign stall_if  = if_req & ~if_done;
  assign stall_mem = d_req & ~d_done;

  // The requester that owns the memory must keep its request up until done.
  assign granted_dropped = ((state == BUSY_D) && !d_req) ||
                           ((state == BUSY_F) && !if_req);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      if_done  <= 1'b0;
      d_done   <= 1'b0;
      if_rdata <= 16'd0;
      d_rdata  <= 16'd0;
      m_en     <= 1'b0;
      m_wr     <= 1'b0;
      m_addr   <= 16'd0;
      m_wdata  <= 16'd0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if ((d_rd & d_wr) || (if_req & if_addr[0])) begin
            err <= 1'b1;
          end
          // A simultaneous read+write request is carried out as a write.
          if (d_req) begin
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
            m_wr    <= d_wr;
            m_en    <= 1'b1;
            cnt     <= 4'd0;
            state   <= BUSY_D;
          end else if (if_req) begin
            m_addr <= if_addr;
            m_wr   <= 1'b0;
            m_en   <= 1'b1;
            cnt    <= 4'd0;
            state  <= BUSY_F;
          end
        end

        BUSY_D, BUSY_F: begin
          if (granted_dropped) begin
            err <= 1'b1;
          end
          if (cnt == LAST_CNT) begin
            if (state == BUSY_D) begin
              d_rdata <= m_rdata;
              d_done  <= 1'b1;
            end else begin
              if_rdata <= m_rdata;
              if_done  <= 1'b1;
            end
            m_en  <= 1'b0;
            m_wr  <= 1'b0;
            cnt   <= 4'd0;
            state <= RESP;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        RESP: begin
          if_done <= 1'b0;
          d_done  <= 1'b0;
          state   <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a transaction-level model predicts grant,
// done and capture cycles from arrival times; extra instances cover LATENCY 1 and 8.
module tb_mem_port_arbiter;

  localparam int LAT      = 2;
  localparam int PH1_START = 400;
  localparam int PH2_START = 440;
  localparam int END_CYC   = 900;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic        d_rd;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        if_done;
  logic [15:0] if_rdata;
  logic        d_done;
  logic [15:0] d_rdata;
  logic        stall_if;
  logic        stall_mem;
  logic        m_en;
  logic        m_wr;
  logic [15:0] m_addr;
  logic [15:0] m_wdata;
  logic [15:0] m_rdata;
  logic        err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .if_done(if_done), .if_rdata(if_rdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .m_en(m_en), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .err(err)
  );

  // Latency-extreme instances exercised with a single fetch each
  logic        x_rst;
  logic        x_req1, x_req8;
  logic [15:0] x_addr;
  logic [15:0] x_mem;
  logic        l1_if_done, l1_d_done, l1_stall_if, l1_stall_mem, l1_m_en, l1_m_wr, l1_err;
  logic [15:0] l1_if_rdata, l1_d_rdata, l1_m_addr, l1_m_wdata;
  logic        l8_if_done, l8_d_done, l8_stall_if, l8_stall_mem, l8_m_en, l8_m_wr, l8_err;
  logic [15:0] l8_if_rdata, l8_d_rdata, l8_m_addr, l8_m_wdata;

  mem_port_arbiter #(.LATENCY(1)) u_lat1 (
    .clk(clk), .rst(x_rst),
    .if_req(x_req1), .if_addr(x_addr),
    .d_rd(1'b0), .d_wr(1'b0), .d_addr(16'd0), .d_wdata(16'd0),
    .if_done(l1_if_done), .if_rdata(l1_if_rdata),
    .d_done(l1_d_done), .d_rdata(l1_d_rdata),
    .stall_if(l1_stall_if), .stall_mem(l1_stall_mem),
    .m_en(l1_m_en), .m_wr(l1_m_wr), .m_addr(l1_m_addr), .m_wdata(l1_m_wdata),
    .m_rdata(x_mem), .err(l1_err)
  );

  mem_port_arbiter #(.LATENCY(8)) u_lat8 (
    .clk(clk), .rst(x_rst),
    .if_req(x_req8), .if_addr(x_addr),
    .d_rd(1'b0), .d_wr(1'b0), .d_addr(16'd0), .d_wdata(16'd0),
    .if_done(l8_if_done), .if_rdata(l8_if_rdata),
    .d_done(l8_d_done), .d_rdata(l8_d_rdata),
    .stall_if(l8_stall_if), .stall_mem(l8_stall_mem),
    .m_en(l8_m_en), .m_wr(l8_m_wr), .m_addr(l8_m_addr), .m_wdata(l8_m_wdata),
    .m_rdata(x_mem), .err(l8_err)
  );

  int check_count = 0;
  int fail_count  = 0;

  // Transaction-level model: arbiter is free from idle_from on; a grant at
  // cycle g occupies memory for g+1..g+LAT and pulses done at g+LAT+1.
  int          cyc;
  int          mode;
  int          idle_from;
  int          g_cycle;
  bit          g_is_data;
  bit          g_write;
  logic [15:0] exp_maddr, exp_mwdata, exp_drdata, exp_frdata;
  bit          exp_err;
  bit          d_pend, f_pend;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    check_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s cycle %0d: got %h expected %h", tag, cyc, observed, expected);
    end
  endtask

  function automatic bit modelBusy();
    return (g_cycle >= 0) && (cyc > g_cycle) && (cyc <= g_cycle + LAT);
  endfunction

  function automatic bit modelDDone();
    return (g_cycle >= 0) && g_is_data && (cyc == g_cycle + LAT + 1);
  endfunction

  function automatic bit modelFDone();
    return (g_cycle >= 0) && !g_is_data && (cyc == g_cycle + LAT + 1);
  endfunction

  task automatic modelReset();
    idle_from  = cyc + 1;
    g_cycle    = -1;
    g_is_data  = 1'b0;
    g_write    = 1'b0;
    exp_maddr  = 16'd0;
    exp_mwdata = 16'd0;
    exp_drdata = 16'd0;
    exp_frdata = 16'd0;
    exp_err    = 1'b0;
    d_pend     = 1'b0;
    f_pend     = 1'b0;
  endtask

  // Requesters behave like pipeline stages: hold until done, then drop or reissue.
  task automatic applyStimulus();
    int kind;
    bit d_seen, f_seen;
    d_seen = modelDDone() && (cyc - 1 == g_cycle + LAT + 1);
    f_seen = modelFDone() && (cyc - 1 == g_cycle + LAT + 1);
    d_seen = (g_cycle >= 0) && g_is_data && (cyc == g_cycle + LAT + 2);
    f_seen = (g_cycle >= 0) && !g_is_data && (cyc == g_cycle + LAT + 2);
    if (d_seen) d_pend = 1'b0;
    if (f_seen) f_pend = 1'b0;
    rst = 1'b0;
    if (cyc == PH1_START || cyc == PH2_START) rst = 1'b1;
    if (mode == 2 && $urandom_range(99) == 0) rst = 1'b1;
    if (mode == 1 && g_cycle >= 0 && !g_is_data && cyc == g_cycle + 1) rst = 1'b1;
    if (mode == 2 && d_pend && $urandom_range(19) == 0) d_pend = 1'b0;
    if (mode == 2 && f_pend && $urandom_range(19) == 0) f_pend = 1'b0;
    if (!d_pend && mode != 1 && $urandom_range(2) == 0) begin
      d_pend  = 1'b1;
      kind    = $urandom_range(7);
      d_wr    = (kind < 3) || (mode == 2 && kind == 7);
      d_rd    = (kind >= 3);
      d_addr  = 16'($urandom);
      d_wdata = 16'($urandom);
    end
    if (!d_pend) begin
      d_rd   = 1'b0;
      d_wr   = 1'b0;
      d_addr = 16'($urandom);
    end
    if (!f_pend && $urandom_range(1) == 0) begin
      f_pend  = 1'b1;
      if_addr = 16'($urandom) & 16'hFFFE;
      if (mode == 2 && $urandom_range(9) == 0) if_addr = if_addr | 16'h0001;
    end
    if_req  = f_pend;
    m_rdata = 16'($urandom);
  endtask

  task automatic checkAndAdvance();
    bit exp_fd, exp_dd, exp_men;
    exp_fd  = modelFDone();
    exp_dd  = modelDDone();
    exp_men = modelBusy();
    checkOutput("if_done",   if_done,   exp_fd);
    checkOutput("d_done",    d_done,    exp_dd);
    checkOutput("m_en",      m_en,      exp_men);
    checkOutput("m_wr",      m_wr,      exp_men && g_write);
    checkOutput("stall_if",  stall_if,  if_req && !exp_fd);
    checkOutput("stall_mem", stall_mem, (d_rd || d_wr) && !exp_dd);
    checkOutput("err",       err,       exp_err);
    checkOutput("if_rdata",  if_rdata,  exp_frdata);
    checkOutput("d_rdata",   d_rdata,   exp_drdata);
    checkOutput("m_addr",    m_addr,    exp_maddr);
    checkOutput("m_wdata",   m_wdata,   exp_mwdata);
    if (rst) begin
      modelReset();
    end else begin
      if (g_cycle >= 0 && cyc == g_cycle + LAT) begin
        if (g_is_data) exp_drdata = m_rdata;
        else           exp_frdata = m_rdata;
      end
      if (exp_men && (g_is_data ? !(d_rd || d_wr) : !if_req)) exp_err = 1'b1;
      if (cyc >= idle_from) begin
        if (d_rd && d_wr) exp_err = 1'b1;
        if (if_req && if_addr[0]) exp_err = 1'b1;
        if (d_rd || d_wr) begin
          g_cycle    = cyc;
          g_is_data  = 1'b1;
          g_write    = d_wr;
          exp_maddr  = d_addr;
          exp_mwdata = d_wdata;
          idle_from  = cyc + LAT + 2;
        end else if (if_req) begin
          g_cycle   = cyc;
          g_is_data = 1'b0;
          g_write   = 1'b0;
          exp_maddr = if_addr;
          idle_from = cyc + LAT + 2;
        end
      end
    end
  endtask

  initial begin
    int n1, n8;
    rst     = 1'b1;
    x_rst   = 1'b1;
    x_req1  = 1'b0;
    x_req8  = 1'b0;
    x_addr  = 16'h0010;
    x_mem   = 16'hBEEF;
    if_req  = 1'b0;
    if_addr = 16'd0;
    d_rd    = 1'b0;
    d_wr    = 1'b0;
    d_addr  = 16'd0;
    d_wdata = 16'd0;
    m_rdata = 16'd0;
    mode    = 0;
    cyc     = 0;
    repeat (2) @(posedge clk);
    modelReset();
    idle_from = 0;

    for (int c = 0; c < END_CYC; c++) begin
      cyc  = c;
      mode = (c < PH1_START) ? 0 : (c < PH2_START) ? 1 : 2;
      #1;
      applyStimulus();
      @(negedge clk);
      checkAndAdvance();
      @(posedge clk);
    end

    // Single fetch on the LATENCY=1 and LATENCY=8 instances
    n1 = -1;
    n8 = -1;
    #1;
    x_rst = 1'b0;
    for (int n = 0; n < 14; n++) begin
      @(posedge clk);
      #1;
      cyc    = n;
      x_req1 = (n1 < 0);
      x_req8 = (n8 < 0);
      @(negedge clk);
      if (n == 1) begin
        checkOutput("lat1_m_en",   l1_m_en,   1'b1);
        checkOutput("lat1_m_addr", l1_m_addr, 16'h0010);
        checkOutput("lat8_m_en",   l8_m_en,   1'b1);
        checkOutput("lat8_m_addr", l8_m_addr, 16'h0010);
      end
      if (l1_if_done && n1 < 0) begin
        n1 = n;
        checkOutput("lat1_if_rdata", l1_if_rdata, 16'hBEEF);
        checkOutput("lat1_stall_if", l1_stall_if, 1'b0);
      end
      if (l8_if_done && n8 < 0) begin
        n8 = n;
        checkOutput("lat8_if_rdata", l8_if_rdata, 16'hBEEF);
        checkOutput("lat8_stall_if", l8_stall_if, 1'b0);
      end
    end
    checkOutput("lat1_done_cycle", 16'(n1), 16'd2);
    checkOutput("lat8_done_cycle", 16'(n8), 16'd9);
    checkOutput("lat1_err",        l1_err,       1'b0);
    checkOutput("lat8_err",        l8_err,       1'b0);
    checkOutput("lat1_d_side",     {l1_d_done, l1_stall_mem, l1_m_wr}, 16'd0);
    checkOutput("lat8_d_side",     {l8_d_done, l8_stall_mem, l8_m_wr}, 16'd0);
    checkOutput("lat1_d_rdata",    l1_d_rdata ^ l1_m_wdata, 16'd0);
    checkOutput("lat8_d_rdata",    l8_d_rdata ^ l8_m_wdata, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
    $finish;
  end

endmodule
